// File: rtl/digital_clock_multi_alarm.sv
// 12/24-hour time-of-day counter with NUM_ALARMS programmable alarm slots and a
// shared ring/snooze controller. Time and alarms are held in 24-hour form internally.
module digital_clock_multi_alarm #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_clock_sec,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_mode_24h,
  input  logic                  i_set_time,
  input  logic [4:0]            i_set_hour,
  input  logic [5:0]            i_set_minute,
  input  logic                  i_set_pm,
  input  logic                  i_alarm_wr_en,
  input  logic [IDX_W-1:0]      i_alarm_wr_idx,
  input  logic [4:0]            i_alarm_wr_hour,
  input  logic [5:0]            i_alarm_wr_minute,
  input  logic                  i_alarm_wr_pm,
  input  logic                  i_alarm_wr_enable,
  input  logic                  i_snooze,
  input  logic                  i_alarm_stop,
  output logic [4:0]            o_hours,
  output logic [5:0]            o_minutes,
  output logic [5:0]            o_seconds,
  output logic                  o_am_pm,
  output logic                  o_alarm_ringing,
  output logic [IDX_W-1:0]      o_ringing_idx,
  output logic [NUM_ALARMS-1:0] o_alarm_enabled,
  output logic                  o_set_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE
  } state_t;

  localparam logic [11:0] RING_LOAD = 12'(RING_SEC);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  function automatic logic hm_valid(input logic [4:0] h, input logic [5:0] m, input logic m24);
    logic h_ok;
    h_ok = m24 ? (h <= 5'd23) : ((h >= 5'd1) && (h <= 5'd12));
    return h_ok && (m <= 6'd59);
  endfunction

  function automatic logic [4:0] to_hour24(input logic [4:0] h, input logic pm, input logic m24);
    logic [4:0] r;
    if (m24)              r = h;
    else if (h == 5'd12)  r = pm ? 5'd12 : 5'd0;
    else                  r = pm ? (h + 5'd12) : h;
    return r;
  endfunction

  // Time-of-day registers
  logic [4:0] r_hour24;
  logic [5:0] r_minute;
  logic [5:0] r_second;

  // Alarm slot storage
  logic [4:0]            r_al_hour [NUM_ALARMS];
  logic [5:0]            r_al_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_al_en;

  // Ring/snooze controller
  state_t           r_state;
  logic [11:0]      r_ring_cnt;
  logic [11:0]      r_snz_cnt;
  logic [IDX_W-1:0] r_ringing_idx;
  logic             r_set_err;

  logic             w_set_ok;
  logic             w_set_bad;
  logic             w_idx_ok;
  logic             w_wr_ok;
  logic             w_wr_bad;
  logic             w_adv;
  logic [4:0]       w_wr_hour24;
  logic [4:0]       w_nxt_hour;
  logic [5:0]       w_nxt_min;
  logic [5:0]       w_nxt_sec;
  logic             w_eval;
  logic             w_match;
  logic [IDX_W-1:0] w_match_idx;
  state_t           w_state_nxt;
  logic [11:0]      w_ring_cnt_nxt;
  logic [11:0]      w_snz_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_set_ok    = i_set_time && hm_valid(i_set_hour, i_set_minute, i_mode_24h);
  assign w_set_bad   = i_set_time && !w_set_ok;
  assign w_idx_ok    = 32'(i_alarm_wr_idx) < NUM_ALARMS;
  assign w_wr_ok     = i_alarm_wr_en && w_idx_ok &&
                       hm_valid(i_alarm_wr_hour, i_alarm_wr_minute, i_mode_24h);
  assign w_wr_bad    = i_alarm_wr_en && !w_wr_ok;
  // A set_time request, valid or not, swallows the tick of that cycle.
  assign w_adv       = i_tick && !i_set_time;
  assign w_wr_hour24 = to_hour24(i_alarm_wr_hour, i_alarm_wr_pm, i_mode_24h);

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    w_nxt_hour = r_hour24;
    w_nxt_min  = r_minute;
    w_nxt_sec  = r_second;
    if (w_set_ok) begin
      w_nxt_hour = to_hour24(i_set_hour, i_set_pm, i_mode_24h);
      w_nxt_min  = i_set_minute;
      w_nxt_sec  = 6'd0;
    end else if (w_adv) begin
      if (r_second == 6'd59) begin
        w_nxt_sec = 6'd0;
        if (r_minute == 6'd59) begin
          w_nxt_min  = 6'd0;
          w_nxt_hour = (r_hour24 == 5'd23) ? 5'd0 : (r_hour24 + 5'd1);
        end else begin
          w_nxt_min = r_minute + 6'd1;
        end
      end else begin
        w_nxt_sec = r_second + 6'd1;
      end
    end
  end

  // Matches are judged only when the next-state time arrives on a second-0 boundary.
  assign w_eval = w_set_ok || (w_adv && (w_nxt_sec == 6'd0));

  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_al_en[i] && (r_al_hour[i] == w_nxt_hour) && (r_al_min[i] == w_nxt_min)) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
    end
    if (!w_eval) w_match = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clock_sec) begin
    if (i_reset) begin
      r_hour24  <= 5'd0;
      r_minute  <= 6'd0;
      r_second  <= 6'd0;
      r_set_err <= 1'b0;
    end else begin
      r_hour24  <= w_nxt_hour;
      r_minute  <= w_nxt_min;
      r_second  <= w_nxt_sec;
      r_set_err <= w_set_bad || w_wr_bad;
    end
  end

  // NOTE: slot contents are reset along with the enables so a re-enabled slot never revives a stale time.
  always_ff @(posedge i_clock_sec) begin
    if (i_reset) begin
      r_al_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_hour[i] <= 5'd0;
        r_al_min[i]  <= 6'd0;
      end
    end else if (w_wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (IDX_W'(i) == i_alarm_wr_idx) begin
          r_al_hour[i] <= w_wr_hour24;
          r_al_min[i]  <= i_alarm_wr_minute;
          r_al_en[i]   <= i_alarm_wr_enable;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_idx_nxt      = r_ringing_idx;
    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          w_state_nxt    = S_RING;
          w_idx_nxt      = w_match_idx;
          w_ring_cnt_nxt = RING_LOAD;
        end
      end
      S_RING: begin
        if (i_alarm_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_snooze) begin
          w_state_nxt   = S_SNOOZE;
          w_snz_cnt_nxt = SNZ_LOAD;
        end else if (w_adv) begin
          if (r_ring_cnt <= 12'd1) w_state_nxt = S_IDLE;
          else                     w_ring_cnt_nxt = r_ring_cnt - 12'd1;
        end
      end
      S_SNOOZE: begin
        if (i_alarm_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_match) begin
          w_state_nxt    = S_RING;
          w_idx_nxt      = w_match_idx;
          w_ring_cnt_nxt = RING_LOAD;
        end else if (w_adv) begin
          if (r_snz_cnt <= 12'd1) begin
            w_state_nxt    = S_RING;
            w_ring_cnt_nxt = RING_LOAD;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 12'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Loading a new time abandons any ring in progress, but the new time may itself match.
    if (w_set_ok) begin
      w_state_nxt = S_IDLE;
      if (w_match) begin
        w_state_nxt    = S_RING;
        w_idx_nxt      = w_match_idx;
        w_ring_cnt_nxt = RING_LOAD;
      end
    end
  end

  always_ff @(posedge i_clock_sec) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ring_cnt    <= 12'd0;
      r_snz_cnt     <= 12'd0;
      r_ringing_idx <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ring_cnt    <= w_ring_cnt_nxt;
      r_snz_cnt     <= w_snz_cnt_nxt;
      r_ringing_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    if (i_mode_24h)              o_hours = r_hour24;
    else if (r_hour24 == 5'd0)   o_hours = 5'd12;
    else if (r_hour24 <= 5'd12)  o_hours = r_hour24;
    else                         o_hours = r_hour24 - 5'd12;
  end

  assign o_minutes       = r_minute;
  assign o_seconds       = r_second;
  assign o_am_pm         = (r_hour24 >= 5'd12);
  assign o_alarm_ringing = (r_state == S_RING);
  assign o_ringing_idx   = r_ringing_idx;
  assign o_alarm_enabled = r_al_en;
  assign o_set_err       = r_set_err;

endmodule

// File: tb/tb_digital_clock_multi_alarm.sv
// Directed bench for digital_clock_multi_alarm: a table of time-set/tick vectors
// followed by hand-written alarm, snooze, stop and reset sequences.
module tb_digital_clock_multi_alarm;

  localparam int NUM_ALARMS = 4;
  localparam int IDX_W      = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  tick;
  logic                  mode_24h;
  logic                  set_time;
  logic [4:0]            set_hour;
  logic [5:0]            set_minute;
  logic                  set_pm;
  logic                  alarm_wr_en;
  logic [IDX_W-1:0]      alarm_wr_idx;
  logic [4:0]            alarm_wr_hour;
  logic [5:0]            alarm_wr_minute;
  logic                  alarm_wr_pm;
  logic                  alarm_wr_enable;
  logic                  snooze;
  logic                  alarm_stop;
  logic [4:0]            hours;
  logic [5:0]            minutes;
  logic [5:0]            seconds;
  logic                  am_pm;
  logic                  alarm_ringing;
  logic [IDX_W-1:0]      ringing_idx;
  logic [NUM_ALARMS-1:0] alarm_enabled;
  logic                  set_err;

  int n_checks = 0;
  int n_errors = 0;

  digital_clock_multi_alarm #(
    .NUM_ALARMS(NUM_ALARMS),
    .SNOOZE_MIN(5),
    .RING_SEC  (60)
  ) dut (
    .i_clock_sec      (clk),
    .i_reset          (reset),
    .i_tick           (tick),
    .i_mode_24h       (mode_24h),
    .i_set_time       (set_time),
    .i_set_hour       (set_hour),
    .i_set_minute     (set_minute),
    .i_set_pm         (set_pm),
    .i_alarm_wr_en    (alarm_wr_en),
    .i_alarm_wr_idx   (alarm_wr_idx),
    .i_alarm_wr_hour  (alarm_wr_hour),
    .i_alarm_wr_minute(alarm_wr_minute),
    .i_alarm_wr_pm    (alarm_wr_pm),
    .i_alarm_wr_enable(alarm_wr_enable),
    .i_snooze         (snooze),
    .i_alarm_stop     (alarm_stop),
    .o_hours          (hours),
    .o_minutes        (minutes),
    .o_seconds        (seconds),
    .o_am_pm          (am_pm),
    .o_alarm_ringing  (alarm_ringing),
    .o_ringing_idx    (ringing_idx),
    .o_alarm_enabled  (alarm_enabled),
    .o_set_err        (set_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode24;
    logic       set;
    logic [4:0] hr;
    logic [5:0] mn;
    logic       pm;
    logic       tk;
    int         eh;
    int         em;
    int         es;
    int         eap;
    int         eerr;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic m24, input logic st, input int h, input int m,
                              input logic pm, input logic tk, input int eh, input int em,
                              input int es, input int eap, input int eerr);
    vec_t v;
    v.mode24 = m24; v.set = st; v.hr = 5'(h); v.mn = 6'(m); v.pm = pm; v.tk = tk;
    v.eh = eh; v.em = em; v.es = es; v.eap = eap; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges; outputs are then sampled 1 time unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_set(input int h, input int m, input logic pm);
    set_time = 1'b1; set_hour = 5'(h); set_minute = 6'(m); set_pm = pm;
    cyc(1);
    set_time = 1'b0;
  endtask

  task automatic wr_alarm(input int idx, input int h, input int m, input logic pm, input logic en);
    alarm_wr_en = 1'b1; alarm_wr_idx = IDX_W'(idx); alarm_wr_hour = 5'(h);
    alarm_wr_minute = 6'(m); alarm_wr_pm = pm; alarm_wr_enable = en;
    cyc(1);
    alarm_wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; mode_24h = 1'b0; set_time = 1'b0; set_hour = '0;
    set_minute = '0; set_pm = 1'b0; alarm_wr_en = 1'b0; alarm_wr_idx = '0;
    alarm_wr_hour = '0; alarm_wr_minute = '0; alarm_wr_pm = 1'b0; alarm_wr_enable = 1'b0;
    snooze = 1'b0; alarm_stop = 1'b0;

    // Reset state
    cyc(1);
    reset = 1'b0;
    check("reset_hours_12h", hours, 12);
    check("reset_minutes", minutes, 0);
    check("reset_seconds", seconds, 0);
    check("reset_am_pm", am_pm, 0);
    check("reset_ringing", alarm_ringing, 0);
    check("reset_idx", ringing_idx, 0);
    check("reset_enabled", alarm_enabled, 0);
    check("reset_set_err", set_err, 0);
    mode_24h = 1'b1; #1;
    check("reset_hours_24h", hours, 0);

    // One hour of ticks in 12h mode
    mode_24h = 1'b0; tick = 1'b1;
    cyc(3600);
    tick = 1'b0;
    check("hour1_hours", hours, 1);
    check("hour1_minutes", minutes, 0);
    check("hour1_seconds", seconds, 0);
    check("hour1_am_pm", am_pm, 0);
    mode_24h = 1'b1; #1;
    check("hour1_hours_24h", hours, 1);

    //              m24   set  hr  mn  pm    tk    eh  em  es ap err
    vecs[0]  = mk(1'b0, 1'b1, 12,  0, 1'b0, 1'b0, 12,  0, 0, 0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 12, 15, 1'b1, 1'b0, 12, 15, 0, 1, 0);
    vecs[2]  = mk(1'b0, 1'b1, 13, 20, 1'b0, 1'b0, 12, 15, 0, 1, 1);
    vecs[3]  = mk(1'b0, 1'b0,  0,  0, 1'b0, 1'b1, 12, 15, 1, 1, 0);
    vecs[4]  = mk(1'b0, 1'b1,  0, 10, 1'b0, 1'b1, 12, 15, 1, 1, 1);
    vecs[5]  = mk(1'b1, 1'b1, 23, 45, 1'b0, 1'b0, 23, 45, 0, 1, 0);
    vecs[6]  = mk(1'b1, 1'b1, 24,  0, 1'b0, 1'b0, 23, 45, 0, 1, 1);
    vecs[7]  = mk(1'b1, 1'b1,  5, 60, 1'b0, 1'b0, 23, 45, 0, 1, 1);
    vecs[8]  = mk(1'b0, 1'b1,  7,  5, 1'b1, 1'b0,  7,  5, 0, 1, 0);
    vecs[9]  = mk(1'b1, 1'b0,  0,  0, 1'b0, 1'b1, 19,  5, 1, 1, 0);
    vecs[10] = mk(1'b1, 1'b1,  0,  0, 1'b0, 1'b0,  0,  0, 0, 0, 0);
    vecs[11] = mk(1'b0, 1'b0,  0,  0, 1'b0, 1'b1, 12,  0, 1, 0, 0);
    vecs[12] = mk(1'b0, 1'b1,  1, 30, 1'b0, 1'b1,  1, 30, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      mode_24h = vecs[i].mode24; set_time = vecs[i].set; set_hour = vecs[i].hr;
      set_minute = vecs[i].mn; set_pm = vecs[i].pm; tick = vecs[i].tk;
      cyc(1);
      check($sformatf("vec%0d_hours", i), hours, vecs[i].eh);
      check($sformatf("vec%0d_minutes", i), minutes, vecs[i].em);
      check($sformatf("vec%0d_seconds", i), seconds, vecs[i].es);
      check($sformatf("vec%0d_am_pm", i), am_pm, vecs[i].eap);
      check($sformatf("vec%0d_set_err", i), set_err, vecs[i].eerr);
    end
    set_time = 1'b0; tick = 1'b0;

    // 11:59 PM rolls over to midnight
    mode_24h = 1'b0;
    do_set(11, 59, 1'b1);
    check("pm1159_hours", hours, 11);
    check("pm1159_am_pm", am_pm, 1);
    tick = 1'b1;
    cyc(59);
    check("pre_midnight_seconds", seconds, 59);
    check("pre_midnight_am_pm", am_pm, 1);
    cyc(1);
    tick = 1'b0;
    mode_24h = 1'b1; #1;
    check("midnight_hours", hours, 0);
    check("midnight_minutes", minutes, 0);
    check("midnight_seconds", seconds, 0);
    check("midnight_am_pm", am_pm, 0);

    // Two slots at 07:30: lowest index wins, auto-stop after 60 ticks
    wr_alarm(2, 7, 30, 1'b0, 1'b1);
    wr_alarm(0, 7, 30, 1'b0, 1'b1);
    check("enabled_slots_0_2", alarm_enabled, 4'b0101);
    do_set(7, 29, 1'b0);
    tick = 1'b1;
    cyc(59);
    check("pre_alarm_ringing", alarm_ringing, 0);
    cyc(1);
    check("alarm_ringing", alarm_ringing, 1);
    check("alarm_idx_lowest", ringing_idx, 0);
    check("alarm_minutes", minutes, 30);
    cyc(59);
    check("ring_tick59", alarm_ringing, 1);
    cyc(1);
    check("ring_autostop", alarm_ringing, 0);

    // set_time onto an alarm rings, then snooze for exactly 300 ticks
    tick = 1'b0;
    do_set(7, 30, 1'b0);
    check("set_match_ringing", alarm_ringing, 1);
    tick = 1'b1;
    cyc(5);
    check("ring_after5", alarm_ringing, 1);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    check("snoozed_ringing", alarm_ringing, 0);
    wr_alarm(0, 7, 30, 1'b0, 1'b0);
    check("slot0_disabled", alarm_enabled, 4'b0100);
    cyc(298);
    check("snooze_tick299", alarm_ringing, 0);
    cyc(1);
    check("snooze_rering", alarm_ringing, 1);
    check("snooze_rering_idx", ringing_idx, 0);
    snooze = 1'b1; alarm_stop = 1'b1;
    cyc(1);
    snooze = 1'b0; alarm_stop = 1'b0;
    check("stop_wins_ringing", alarm_ringing, 0);
    cyc(350);
    check("stop_stays_idle", alarm_ringing, 0);

    // Disabled slot does not ring; invalid writes are rejected
    tick = 1'b0;
    wr_alarm(1, 8, 0, 1'b0, 1'b0);
    do_set(7, 59, 1'b0);
    tick = 1'b1;
    cyc(60);
    check("disabled_hours", hours, 8);
    check("disabled_no_ring", alarm_ringing, 0);
    wr_alarm(1, 8, 60, 1'b0, 1'b1);
    check("bad_wr_set_err", set_err, 1);
    check("bad_wr_slot_unchanged", alarm_enabled, 4'b0100);
    cyc(1);
    check("set_err_pulse_ends", set_err, 0);
    tick = 1'b0;
    set_time = 1'b1; set_hour = 5'd25; set_minute = 6'd0;
    alarm_wr_en = 1'b1; alarm_wr_idx = 2'd3; alarm_wr_hour = 5'd1; alarm_wr_minute = 6'd61;
    alarm_wr_enable = 1'b1;
    cyc(1);
    set_time = 1'b0; alarm_wr_en = 1'b0;
    check("double_bad_set_err", set_err, 1);
    check("double_bad_hours", hours, 8);
    check("double_bad_enabled", alarm_enabled, 4'b0100);
    cyc(1);
    check("double_bad_single_pulse", set_err, 0);

    // Slot 2 is now the lowest enabled match; reset mid-ring
    do_set(7, 30, 1'b0);
    check("slot2_ringing", alarm_ringing, 1);
    check("slot2_idx", ringing_idx, 2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midring_reset_ringing", alarm_ringing, 0);
    check("midring_reset_enabled", alarm_enabled, 0);
    check("midring_reset_idx", ringing_idx, 0);

    // Alarms written in 12h form; set_time during SNOOZE onto another slot
    mode_24h = 1'b0;
    wr_alarm(1, 12, 0, 1'b1, 1'b1);
    wr_alarm(3, 6, 0, 1'b0, 1'b1);
    mode_24h = 1'b1;
    check("enabled_slots_1_3", alarm_enabled, 4'b1010);
    do_set(12, 0, 1'b0);
    check("noon_ringing", alarm_ringing, 1);
    check("noon_idx", ringing_idx, 1);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    check("noon_snoozed", alarm_ringing, 0);
    do_set(6, 0, 1'b0);
    check("snooze_set_ringing", alarm_ringing, 1);
    check("snooze_set_idx", ringing_idx, 3);
    check("snooze_set_hours", hours, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
